mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped serial transmit peripheral for the RISC-V CPU's data bus, in the CPU → outside-world direction. Store instructions to its DATA address push bytes into a small FIFO. A serializer drains the FIFO onto a single 8N1 line, LSB first. Load instructions to its STATUS address return FIFO and serializer state, so firmware can poll before writing.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit. Legal range is 2..65535.
- FIFO_DEPTH, default 4: number of byte entries. Must be a power of two, at least 2.
- ADDR_DATA, default 32'h0000_0100: word address of the write-only DATA register.
- ADDR_STATUS, default 32'h0000_0104: word address of the read-only STATUS register.
- clk, input, 1: the single clock. All logic is updated on its rising edge.
- rst, input, 1: synchronous, active-low reset. Sampled on the rising edge of clk.
- we, input, 1: bus write strobe. Valid for exactly one cycle per store.
- re, input, 1: bus read strobe. Valid for exactly one cycle per load.
- addr, input, 32: bus address. Compared in full against ADDR_DATA and ADDR_STATUS.
- wdata, input, 32: store data. Only bits [7:0] are used.
- rdata, output, 32: registered load data.
- tx, output, 1: serial line. Idles high. Registered.
- busy, output, 1: high when the FIFO is non-empty or a frame is in flight.

## Operation
- **Push:** we=1 with addr==ADDR_DATA.
  - If the FIFO is not full, wdata[7:0] is written at the write pointer and count increments.
  - If the FIFO is full, the byte is dropped and sticky flag ovf is set.
- **Read STATUS:** re=1 with addr==ADDR_STATUS.
  - rdata is loaded with {27'b0, ovf, full, empty, tx_active, busy}.
  - ovf is cleared by the same edge.
  - If an overflow occurs on that same edge, ovf stays set.
- Any other re loads rdata=0. Writes to unmapped addresses, or to STATUS, are ignored.
- **FIFO:** circular buffer with wrapping read/write pointers and a count from 0 to FIFO_DEPTH.
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - Simultaneous push and pop when full: both happen and count is unchanged.
  - Simultaneous push and pop with count==1: both happen and count stays 1.
- **Serializer FSM, states IDLE, START, DATA, STOP:**
  - IDLE: tx=1. If the FIFO is non-empty, pop into shift register sh, clear baud counter bc and bit index bi, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=sh[0] for CLKS_PER_BIT cycles, then shift sh right. When bi==7, go to STOP; otherwise increment bi.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Derived signals:** tx_active = (state != IDLE); busy = tx_active | ~empty.
- bc counts 0..CLKS_PER_BIT-1, with width $clog2(CLKS_PER_BIT). A bit period ends when bc==CLKS_PER_BIT-1 and bc wraps to 0.

## Timing
- **Reset (rst=0 at an edge):**
  - Outputs: tx=1, rdata=0, busy=0.
  - Internal state: state=IDLE, count=0, pointers=0, ovf=0, bc=0, bi=0.
  - Reset mid-frame aborts the frame: tx is 1 after that edge and FIFO contents are discarded.
- **Push to serial output:**
  - A push sampled at edge E is reflected in STATUS and busy after E.
  - The FSM pops at edge E+1, so tx falls after E+1.
  - The frame lasts exactly 10·CLKS_PER_BIT cycles.
- **Back-to-back frames:** the stop bit is immediately followed by the next start bit.
- **Read latency:** one cycle. rdata is valid after the edge that samples re and holds until the next re or reset.
- **Idle detection:** busy falls on the edge that ends the last stop bit.

## Test plan
- **Reset:** rst=0 for 2 cycles, then 1 → tx=1, busy=0, rdata=0. Then read STATUS → rdata=32'h0000_0004 (empty only).
- **Single frame (CLKS_PER_BIT=4):** write 32'hFFFF_FF55 to DATA.
  - tx falls exactly 2 edges after the write.
  - Bit sequence: 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
  - busy=0 exactly 40 cycles after tx falls.
- **Overflow (CLKS_PER_BIT=16, FIFO_DEPTH=4):** write 0x01..0x06 on consecutive cycles.
  - First byte is popped into the serializer; next 4 fill the FIFO; sixth is dropped.
  - STATUS read → ovf=1, full=1, rdata=32'h0000_001B.
  - Second STATUS read → ovf=0.
- **Back-to-back drain:** write 0xA5 then 0x3C.
  - 20·CLKS_PER_BIT continuous frame cycles.
  - Decoded bytes are A5 then 3C.
  - No high gap longer than one stop bit between the frames.
- **Reset mid-frame:** during the DATA bit 3 of 0xF0, with 2 bytes queued, pulse rst=0 for 1 cycle.
  - tx=1 after that edge, busy=0.
  - No further start bit for 100 cycles.
- **Unmapped access:** write to ADDR_STATUS and to 32'h0000_0108 → no frame is sent. Read of 32'h0000_0108 → rdata=0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: DATA stores feed a byte FIFO that a
// serializer drains LSB first; STATUS loads report FIFO/serializer state.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] ADDR_DATA    = 32'h0000_0100,
  parameter logic [31:0] ADDR_STATUS  = 32'h0000_0104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned BCW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BC_ONE   = BCW'(1);
  localparam logic [PW:0]    CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    sh_q;
  logic [BCW-1:0] bc_q;
  logic [2:0]    bi_q;
  logic          tx_q;
  logic [31:0]   rdata_q;

  logic empty, full, tx_active, push, push_ok, pop, bit_end, stat_rd;
  logic unused_wdata;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_FULL);
  assign tx_active = (state_q != S_IDLE);
  assign bit_end   = (bc_q == BC_LAST);
  assign push      = we && (addr == ADDR_DATA);
  assign stat_rd   = re && (addr == ADDR_STATUS);
  assign pop       = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  // A full FIFO still accepts a byte when the serializer pops on the same edge.
  assign push_ok   = push && (!full || pop);
  assign unused_wdata = ^wdata[31:8];

  assign tx    = tx_q;
  assign busy  = tx_active | ~empty;
  assign rdata = rdata_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (pop && !push_ok) cnt_d = cnt_q - CNT_ONE;
    ovf_d = (ovf_q && !stat_rd) || (push && !push_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + PTR_ONE;
      if (pop)     rp_q <= rp_q + PTR_ONE;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (re) rdata_q <= stat_rd ? {27'b0, ovf_q, full, empty, tx_active, busy} : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bc_q    <= '0;
      bi_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            sh_q    <= mem_q[rp_q];
            bc_q    <= '0;
            bi_q    <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bc_q    <= '0;
            tx_q    <= sh_q[0];
            state_q <= S_DATA;
          end else begin
            bc_q <= bc_q + BC_ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bc_q <= '0;
            sh_q <= {1'b0, sh_q[7:1]};
            if (bi_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bi_q <= bi_q + 3'd1;
              tx_q <= sh_q[1];
            end
          end else begin
            bc_q <= bc_q + BC_ONE;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            bc_q <= '0;
            if (pop) begin
              sh_q    <= mem_q[rp_q];
              bi_q    <= '0;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            bc_q <= bc_q + BC_ONE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a line monitor decodes frames and checks them against
// bytes queued when each DATA store is driven.
module tb_mmio_uart_tx;

  localparam int          CPB    = 4;
  localparam logic [31:0] A_DATA = 32'h0000_0100;
  localparam logic [31:0] A_STAT = 32'h0000_0104;
  localparam logic [31:0] A_NONE = 32'h0000_0108;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx, busy;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4),
    .ADDR_DATA   (A_DATA),
    .ADDR_STATUS (A_STAT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .re   (re),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [7:0] sb[$];

  // Reset as seen by the DUT on the last rising edge; lets the monitor abort race-free.
  logic rst_seen_q = 1'b1;
  always @(posedge clk) rst_seen_q <= !rst;

  int          mon_pos = -1;
  int          bitn;
  logic [7:0]  mon_byte = '0;
  int unsigned ncyc = 0;
  int unsigned starts_total = 0;
  int unsigned last_start = 0;
  int unsigned prev_start = 0;

  always @(negedge clk) begin
    ncyc++;
    if (rst_seen_q) begin
      mon_pos = -1;
      sb.delete();
    end else if (mon_pos < 0) begin
      if (tx === 1'b0) begin
        mon_pos = 0;
        starts_total++;
        prev_start = last_start;
        last_start = ncyc;
      end
    end else begin
      mon_pos++;
    end
    if (mon_pos >= 0 && (mon_pos % CPB) == CPB / 2) begin
      bitn = mon_pos / CPB;
      if (bitn == 0) begin
        check_eq("start_bit", 32'(tx), 32'd0);
      end else if (bitn <= 8) begin
        mon_byte[bitn-1] = tx;
      end else begin
        check_eq("stop_bit", 32'(tx), 32'd1);
        if (sb.size() == 0) check_eq("unexpected_frame", 32'(mon_byte), 32'h100);
        else                check_eq("frame_byte", 32'(mon_byte), 32'(sb.pop_front()));
        mon_pos = -1;
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input bit accept);
    we = 1'b1;
    addr = a;
    wdata = d;
    if (accept) sb.push_back(d[7:0]);
    @(negedge clk);
    we = 1'b0;
    addr = '0;
    wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    re = 1'b1;
    addr = a;
    @(negedge clk);
    re = 1'b0;
    addr = '0;
    d = rdata;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_tx_low(input int budget, input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(tx), 32'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish in 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  frame;
    int unsigned s0;

    // Reset
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    bus_read(A_STAT, rd);
    check_eq("rst_status", rd, 32'h0000_0004);

    // Single frame with bit-level timing
    bus_write(A_DATA, 32'hFFFF_FF55, 1'b1);
    check_eq("lat_after_push", 32'(tx), 32'd1);
    check_eq("busy_after_push", 32'(busy), 32'd1);
    @(negedge clk);
    frame = {1'b1, 8'h55, 1'b0};
    for (int n = 0; n < 10 * CPB; n++) begin
      if (n > 0) @(negedge clk);
      check_eq($sformatf("frame_bit%0d", n), 32'(tx), 32'(frame[n / CPB]));
    end
    check_eq("busy_last_cycle", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("busy_fall", 32'(busy), 32'd0);
    check_eq("tx_idle", 32'(tx), 32'd1);

    // Overflow: first byte popped, four fill the FIFO, sixth dropped
    for (int i = 1; i <= 6; i++) bus_write(A_DATA, 32'(i), (i <= 5));
    bus_read(A_STAT, rd);
    check_eq("ovf_status", rd, 32'h0000_001B);
    bus_read(A_STAT, rd);
    check_eq("ovf_cleared", rd, 32'h0000_000B);
    wait_idle(400, "ovf_drain");

    // Back-to-back frames
    s0 = starts_total;
    bus_write(A_DATA, 32'h0000_00A5, 1'b1);
    bus_write(A_DATA, 32'h0000_003C, 1'b1);
    wait_idle(200, "b2b_drain");
    check_eq("b2b_frames", 32'(starts_total - s0), 32'd2);
    check_eq("b2b_spacing", 32'(last_start - prev_start), 32'(10 * CPB));
    check_eq("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-frame during data bit 3 of 0xF0 with two bytes queued
    bus_write(A_DATA, 32'h0000_00F0, 1'b1);
    wait_tx_low(10, "mid_start");
    bus_write(A_DATA, 32'h0000_0011, 1'b1);
    bus_write(A_DATA, 32'h0000_0022, 1'b1);
    repeat (15) @(negedge clk);
    check_eq("mid_bit3", 32'(tx), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("mid_rst_tx", 32'(tx), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    s0 = starts_total;
    repeat (100) @(negedge clk);
    check_eq("mid_no_start", 32'(starts_total - s0), 32'd0);
    bus_read(A_STAT, rd);
    check_eq("mid_status", rd, 32'h0000_0004);

    // Unmapped and read-only accesses
    s0 = starts_total;
    bus_write(A_STAT, 32'h0000_0041, 1'b0);
    bus_write(A_NONE, 32'h0000_0042, 1'b0);
    check_eq("unmapped_busy", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    check_eq("unmapped_no_start", 32'(starts_total - s0), 32'd0);
    bus_read(A_STAT, rd);
    check_eq("unmapped_status", rd, 32'h0000_0004);
    bus_read(A_NONE, rd);
    check_eq("unmapped_read", rd, 32'd0);
    bus_read(A_STAT, rd);
    bus_read(A_DATA, rd);
    check_eq("data_read_zero", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
